n1_pbus_arb: RTL

Arbiter sharing the single pipelined Wishbone program bus (pbus) between two initiators. Requester 0 is the instruction fetch path of the flow-control FSM. Requester 1 is the data memory I/O path. The block sits between the N1 core initiators and the external pbus, muxes address and write data, routes ack/err/stall back to the owner, and limits outstanding strobes per grant.

---
 rtl/n1_pbus_arb_pkg.sv | 28 ++
 rtl/n1_pbus_arb_if.sv | 50 +++++
 rtl/n1_pbus_ostd_cnt.sv | 35 +++
 rtl/n1_pbus_arb.sv | 124 ++++++++++++
 4 files changed

// File: rtl/n1_pbus_arb_pkg.sv
// Shared types and helpers for the N1 program-bus arbiter.
package n1_pbus_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_GNT0 = 2'd1,
      ST_GNT1 = 2'd2
   } arb_state_t;

   localparam int OSTD_CNT_WIDTH = 3;

   // last: 0 = req0 was granted last, 1 = req1 was granted last
   function automatic arb_state_t next_grant(input logic cyc0,
                                             input logic cyc1,
                                             input logic last);
      arb_state_t gnt;
      gnt = ST_IDLE;
      if (cyc0 && cyc1) begin
         gnt = last ? ST_GNT0 : ST_GNT1;
      end else if (cyc0) begin
         gnt = ST_GNT0;
      end else if (cyc1) begin
         gnt = ST_GNT1;
      end
      return gnt;
   endfunction

endpackage

// File: rtl/n1_pbus_arb_if.sv
// Requester and pbus signal bundle; master = arbiter side, slave = requesters plus pbus target.
interface n1_pbus_arb_if #(
   parameter int ADR_WIDTH = 14,
   parameter int DAT_WIDTH = 16
);
   logic                 req0_cyc_i;
   logic                 req0_stb_i;
   logic                 req0_we_i;
   logic [ADR_WIDTH-1:0] req0_adr_i;
   logic [DAT_WIDTH-1:0] req0_dat_i;
   logic                 req0_ack_o;
   logic                 req0_err_o;
   logic                 req0_stall_o;

   logic                 req1_cyc_i;
   logic                 req1_stb_i;
   logic                 req1_we_i;
   logic [ADR_WIDTH-1:0] req1_adr_i;
   logic [DAT_WIDTH-1:0] req1_dat_i;
   logic                 req1_ack_o;
   logic                 req1_err_o;
   logic                 req1_stall_o;

   logic                 pbus_cyc_o;
   logic                 pbus_stb_o;
   logic                 pbus_we_o;
   logic [ADR_WIDTH-1:0] pbus_adr_o;
   logic [DAT_WIDTH-1:0] pbus_dat_o;
   logic                 pbus_ack_i;
   logic                 pbus_err_i;
   logic                 pbus_stall_i;

   modport master (
      input  req0_cyc_i, req0_stb_i, req0_we_i, req0_adr_i, req0_dat_i,
      output req0_ack_o, req0_err_o, req0_stall_o,
      input  req1_cyc_i, req1_stb_i, req1_we_i, req1_adr_i, req1_dat_i,
      output req1_ack_o, req1_err_o, req1_stall_o,
      output pbus_cyc_o, pbus_stb_o, pbus_we_o, pbus_adr_o, pbus_dat_o,
      input  pbus_ack_i, pbus_err_i, pbus_stall_i
   );

   modport slave (
      output req0_cyc_i, req0_stb_i, req0_we_i, req0_adr_i, req0_dat_i,
      input  req0_ack_o, req0_err_o, req0_stall_o,
      output req1_cyc_i, req1_stb_i, req1_we_i, req1_adr_i, req1_dat_i,
      input  req1_ack_o, req1_err_o, req1_stall_o,
      input  pbus_cyc_o, pbus_stb_o, pbus_we_o, pbus_adr_o, pbus_dat_o,
      output pbus_ack_i, pbus_err_i, pbus_stall_i
   );
endinterface

// File: rtl/n1_pbus_ostd_cnt.sv
// Saturating up/down count of accepted-but-unanswered pbus strobes.
// Latency: count updates one cycle after inc/dec/clr; full/empty are decoded from the register.
// Backpressure: none inside; the owner stops strobing on full.
module n1_pbus_ostd_cnt
   import n1_pbus_arb_pkg::*;
#(
   parameter int MAX_OSTD = 2
) (
   input  logic                      clk_i,
   input  logic                      sync_rst_i,
   input  logic                      clr,
   input  logic                      inc,
   input  logic                      dec,
   output logic [OSTD_CNT_WIDTH-1:0] cnt,
   output logic                      full,
   output logic                      empty
);

   localparam logic [OSTD_CNT_WIDTH-1:0] MAX_C = OSTD_CNT_WIDTH'(MAX_OSTD);

   assign full  = (cnt == MAX_C);
   assign empty = (cnt == '0);

   // Simultaneous inc and dec cancel; a response with nothing outstanding is dropped
   always_ff @(posedge clk_i) begin
      if (sync_rst_i || clr) begin
         cnt <= '0;
      end else if (inc && !dec && !full) begin
         cnt <= cnt + 1'b1;
      end else if (dec && !inc && !empty) begin
         cnt <= cnt - 1'b1;
      end
   end

endmodule

// File: rtl/n1_pbus_arb.sv
// Round-robin arbiter sharing the pipelined pbus between instruction fetch (req0) and data I/O (req1).
// Latency: grant one cycle after cyc rises, one IDLE bubble between owners; address/data/strobe muxed combinationally.
// Backpressure: owner stall = pbus stall or outstanding limit reached; the non-owner is always stalled.
module n1_pbus_arb
   import n1_pbus_arb_pkg::*;
#(
   parameter int ADR_WIDTH = 14,
   parameter int DAT_WIDTH = 16,
   parameter int MAX_OSTD  = 2
) (
   input  logic                      clk_i,
   input  logic                      sync_rst_i,
   n1_pbus_arb_if.master             bus,
   output logic [1:0]                prb_arb_state_o,
   output logic [OSTD_CNT_WIDTH-1:0] prb_arb_ostd_o
);

   arb_state_t state_q, state_d;
   logic       last_q;

   logic                      ostd_full, ostd_empty, ostd_clr, ostd_inc, ostd_dec;
   logic [OSTD_CNT_WIDTH-1:0] ostd_cnt;

   logic                 cyc_mux, stb_mux, we_mux;
   logic [ADR_WIDTH-1:0] adr_mux;
   logic [DAT_WIDTH-1:0] dat_mux;
   logic                 stall0, stall1, ack0, ack1, err0, err1;

   always_ff @(posedge clk_i) begin
      if (sync_rst_i) begin
         state_q <= ST_IDLE;
         last_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         if (state_q == ST_IDLE && state_d == ST_GNT0) begin
            last_q <= 1'b0;
         end else if (state_q == ST_IDLE && state_d == ST_GNT1) begin
            last_q <= 1'b1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      cyc_mux = 1'b0;
      stb_mux = 1'b0;
      we_mux  = bus.req0_we_i;
      adr_mux = bus.req0_adr_i;
      dat_mux = bus.req0_dat_i;
      stall0  = 1'b1;
      stall1  = 1'b1;
      ack0    = 1'b0;
      ack1    = 1'b0;
      err0    = 1'b0;
      err1    = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            state_d = next_grant(bus.req0_cyc_i, bus.req1_cyc_i, last_q);
         end
         ST_GNT0: begin
            if (!bus.req0_cyc_i) state_d = ST_IDLE;
            cyc_mux = bus.req0_cyc_i;
            stb_mux = bus.req0_stb_i & ~ostd_full;
            stall0  = bus.pbus_stall_i | ostd_full;
            ack0    = bus.pbus_ack_i;
            err0    = bus.pbus_err_i;
         end
         ST_GNT1: begin
            if (!bus.req1_cyc_i) state_d = ST_IDLE;
            cyc_mux = bus.req1_cyc_i;
            stb_mux = bus.req1_stb_i & ~ostd_full;
            we_mux  = bus.req1_we_i;
            adr_mux = bus.req1_adr_i;
            dat_mux = bus.req1_dat_i;
            stall1  = bus.pbus_stall_i | ostd_full;
            ack1    = bus.pbus_ack_i;
            err1    = bus.pbus_err_i;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Owner dropping cyc abandons whatever is still in flight
   assign ostd_clr = (state_q == ST_GNT0 && !bus.req0_cyc_i) ||
                     (state_q == ST_GNT1 && !bus.req1_cyc_i);
   assign ostd_inc = stb_mux & ~bus.pbus_stall_i;
   assign ostd_dec = bus.pbus_ack_i | bus.pbus_err_i;

   n1_pbus_ostd_cnt #(
      .MAX_OSTD (MAX_OSTD)
   ) u_ostd_cnt (
      .clk_i      (clk_i),
      .sync_rst_i (sync_rst_i),
      .clr        (ostd_clr),
      .inc        (ostd_inc),
      .dec        (ostd_dec),
      .cnt        (ostd_cnt),
      .full       (ostd_full),
      .empty      (ostd_empty)
   );

   assign bus.pbus_cyc_o   = cyc_mux;
   assign bus.pbus_stb_o   = stb_mux;
   assign bus.pbus_we_o    = we_mux;
   assign bus.pbus_adr_o   = adr_mux;
   assign bus.pbus_dat_o   = dat_mux;
   assign bus.req0_stall_o = stall0;
   assign bus.req1_stall_o = stall1;
   assign bus.req0_ack_o   = ack0;
   assign bus.req1_ack_o   = ack1;
   assign bus.req0_err_o   = err0;
   assign bus.req1_err_o   = err1;

   assign prb_arb_state_o = state_q;
   assign prb_arb_ostd_o  = ostd_cnt;

`ifdef FORMAL
   a_no_resp_underflow: assert property (@(posedge clk_i) disable iff (sync_rst_i)
      (state_q != ST_IDLE && ostd_dec) |-> !ostd_empty);
`endif

endmodule
